// File: rtl/decode_stage_pipe_if.sv
// Bundle of the decode-stage signals: IF/ID and writeback inputs, the stall
// request back to fetch, and the ID/EX pipeline register contents to EX.
interface decode_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 16
);
  localparam int RW = $clog2(NREGS);

  logic              de_valid;
  logic [31:0]       de_inst;
  logic [XLEN-1:0]   de_pc;
  logic [CTRL_W-1:0] de_ctrl;
  logic              de_dmrd;
  logic              wb_we;
  logic [RW-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              stall_fe;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [RW-1:0]     ex_rs1;
  logic [RW-1:0]     ex_rs2;
  logic [RW-1:0]     ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_dmrd;

  modport master (
    output de_valid, de_inst, de_pc, de_ctrl, de_dmrd, wb_we, wb_rd, wb_data, flush,
    input  stall_fe, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_dmrd
  );

  modport slave (
    input  de_valid, de_inst, de_pc, de_ctrl, de_dmrd, wb_we, wb_rd, wb_data, flush,
    output stall_fe, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_dmrd
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// RISC-V decode stage with integrated ID/EX register: register file with
// write-first writeback bypass, immediate generator, load-use stall counter
// and branch flush.
module decode_stage_pipe #(
  parameter int XLEN            = 32,
  parameter int NREGS           = 32,
  parameter int CTRL_W          = 16,
  parameter int LOAD_USE_STALLS = 1
) (
  input logic               clk,
  input logic               rst_n,
  decode_stage_pipe_if.slave bus
);
  localparam int RW = $clog2(NREGS);
  localparam logic [1:0] STALL_LOAD = 2'(LOAD_USE_STALLS - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Immediate by format, sign-extended from inst[31] to XLEN.
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] inst);
    logic signed [31:0] imm32_s;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm32_s = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm32_s = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32_s = {inst[31:12], 12'h000};
      OP_JAL:                   imm32_s = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                  imm32_s = 32'sd0;
    endcase
    return XLEN'(imm32_s);
  endfunction

  logic [XLEN-1:0]   regs_r [NREGS];
  logic [4:0]        rs1_f_s, rs2_f_s;
  logic [RW-1:0]     rs1_s, rs2_s, rd_s;
  logic [6:0]        opcode_s;
  logic [XLEN-1:0]   rs1_data_s, rs2_data_s, imm_s;
  logic              uses_rs1_s, uses_rs2_s, haz_s, stall_s;
  logic [1:0]        cnt_r;
  logic              ex_valid_r, ex_dmrd_r;
  logic [XLEN-1:0]   ex_pc_r, ex_rs1_data_r, ex_rs2_data_r, ex_imm_r;
  logic [RW-1:0]     ex_rs1_r, ex_rs2_r, ex_rd_r;
  logic [CTRL_W-1:0] ex_ctrl_r;

  assign rs1_f_s  = bus.de_inst[19:15];
  assign rs2_f_s  = bus.de_inst[24:20];
  assign rs1_s    = rs1_f_s[RW-1:0];
  assign rs2_s    = rs2_f_s[RW-1:0];
  assign rd_s     = bus.de_inst[7 +: RW];
  assign opcode_s = bus.de_inst[6:0];
  assign imm_s    = gen_imm(bus.de_inst);

  // rs1 read: out-of-range and x0 read zero, a same-cycle writeback wins.
  always_comb begin
    rs1_data_s = '0;
    if ({1'b0, rs1_f_s} >= 6'(NREGS)) begin
      rs1_data_s = '0;
    end else if (rs1_s == '0) begin
      rs1_data_s = '0;
    end else if (bus.wb_we && (bus.wb_rd == rs1_s)) begin
      rs1_data_s = bus.wb_data;
    end else begin
      rs1_data_s = regs_r[rs1_s];
    end
  end

  // rs2 read: same rules as rs1.
  always_comb begin
    rs2_data_s = '0;
    if ({1'b0, rs2_f_s} >= 6'(NREGS)) begin
      rs2_data_s = '0;
    end else if (rs2_s == '0) begin
      rs2_data_s = '0;
    end else if (bus.wb_we && (bus.wb_rd == rs2_s)) begin
      rs2_data_s = bus.wb_data;
    end else begin
      rs2_data_s = regs_r[rs2_s];
    end
  end

  // Source usage, load-use hazard and the fetch stall request.
  always_comb begin
    uses_rs1_s = !((opcode_s == OP_LUI) || (opcode_s == OP_AUIPC) || (opcode_s == OP_JAL));
    uses_rs2_s = (opcode_s == OP_REG) || (opcode_s == OP_STORE) || (opcode_s == OP_BRANCH);
    haz_s = bus.de_valid && ex_valid_r && ex_dmrd_r && (ex_rd_r != '0) &&
            ((uses_rs1_s && (ex_rd_r == rs1_s)) || (uses_rs2_s && (ex_rd_r == rs2_s)));
    stall_s = !bus.flush && (haz_s || (cnt_r != 2'd0));
  end

  // Register file: x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_rd != '0)) begin
      regs_r[bus.wb_rd] <= bus.wb_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Remaining load-use bubbles after the first; a flush abandons them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 2'd0;
    end else if (bus.flush) begin
      cnt_r <= 2'd0;
    end else if (cnt_r != 2'd0) begin
      cnt_r <= cnt_r - 2'd1;
    end else if (haz_s) begin
      cnt_r <= STALL_LOAD;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // ID/EX register: flush or stall inserts a bubble, otherwise capture DE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r    <= 1'b0;
      ex_pc_r       <= '0;
      ex_rs1_data_r <= '0;
      ex_rs2_data_r <= '0;
      ex_imm_r      <= '0;
      ex_rs1_r      <= '0;
      ex_rs2_r      <= '0;
      ex_rd_r       <= '0;
      ex_ctrl_r     <= '0;
      ex_dmrd_r     <= 1'b0;
    end else if (bus.flush || stall_s) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= '0;
      ex_dmrd_r  <= 1'b0;
    end else begin
      ex_valid_r    <= bus.de_valid;
      ex_pc_r       <= bus.de_pc;
      ex_rs1_data_r <= rs1_data_s;
      ex_rs2_data_r <= rs2_data_s;
      ex_imm_r      <= imm_s;
      ex_rs1_r      <= rs1_s;
      ex_rs2_r      <= rs2_s;
      ex_rd_r       <= rd_s;
      ex_ctrl_r     <= bus.de_valid ? bus.de_ctrl : '0;
      ex_dmrd_r     <= bus.de_valid & bus.de_dmrd;
    end
  end

  assign bus.stall_fe    = stall_s;
  assign bus.ex_valid    = ex_valid_r;
  assign bus.ex_pc       = ex_pc_r;
  assign bus.ex_rs1_data = ex_rs1_data_r;
  assign bus.ex_rs2_data = ex_rs2_data_r;
  assign bus.ex_imm      = ex_imm_r;
  assign bus.ex_rs1      = ex_rs1_r;
  assign bus.ex_rs2      = ex_rs2_r;
  assign bus.ex_rd       = ex_rd_r;
  assign bus.ex_ctrl     = ex_ctrl_r;
  assign bus.ex_dmrd     = ex_dmrd_r;
endmodule
